// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers h/v position from sync strobes, checks line and
// frame lengths, locks after consecutive clean frames and captures visible pixels.
module vga_timing_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACT_START = 144,
  parameter int V_TOTAL     = 525,
  parameter int V_ACT_START = 34,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  input  logic       i_px_en,
  input  logic       i_vga_hsync,
  input  logic       i_vga_vsync,
  input  logic [3:0] i_vga_red,
  input  logic [3:0] i_vga_green,
  input  logic [3:0] i_vga_blue,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue,
  output logic       o_de,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_err
);

  localparam int GW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0]    H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_OFF       = 10'(H_ACT_START);
  localparam logic [9:0]    V_OFF       = 10'(V_ACT_START);
  localparam logic [10:0]   H_ACT_LO    = 11'(H_ACT_START);
  localparam logic [10:0]   H_ACT_HI    = 11'(H_ACT_START + 640);
  localparam logic [10:0]   V_ACT_LO    = 11'(V_ACT_START);
  localparam logic [10:0]   V_ACT_HI    = 11'(V_ACT_START + 480);
  localparam logic [9:0]    CNT_MAX     = 10'd1023;
  localparam logic [9:0]    CNT_NEAR    = 10'd1022;
  localparam logic [GW-1:0] GOOD_ZERO   = GW'(0);
  localparam logic [GW-1:0] GOOD_ONE    = GW'(1);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCK   = 2'd2
  } lock_state_t;

  lock_state_t   state_r;
  lock_state_t   state_next_s;
  logic [GW-1:0] good_r;
  logic [GW-1:0] good_next_s;
  logic [GW-1:0] good_inc_s;

  logic       hs_prev_r;
  logic       vs_prev_r;
  logic       h_armed_r;
  logic       v_armed_r;
  logic [9:0] hcnt_r;
  logic [9:0] vcnt_r;

  logic       hs_fall_s;
  logic       vs_fall_s;
  logic [9:0] hcnt_next_s;
  logic [9:0] vcnt_next_s;
  logic       h_viol_s;
  logic       v_viol_s;
  logic       viol_s;
  logic       visible_s;
  logic       de_s;
  logic [9:0] hcol_s;
  logic [9:0] vrow_s;
  logic       origin_s;

  // Sync edge detection and next counter values for this strobe.
  always_comb begin
    hs_fall_s = i_px_en & ~i_vga_hsync & hs_prev_r;
    vs_fall_s = hs_fall_s & ~i_vga_vsync & vs_prev_r;

    if (hs_fall_s) begin
      hcnt_next_s = 10'd0;
    end else if (hcnt_r == CNT_MAX) begin
      hcnt_next_s = CNT_MAX;
    end else begin
      hcnt_next_s = hcnt_r + 10'd1;
    end

    if (vs_fall_s) begin
      vcnt_next_s = 10'd0;
    end else if (hs_fall_s && (vcnt_r != CNT_MAX)) begin
      vcnt_next_s = vcnt_r + 10'd1;
    end else begin
      vcnt_next_s = vcnt_r;
    end
  end

  // Timing violations and visible-window decode on the updated position.
  always_comb begin
    h_viol_s = (hs_fall_s & ~h_armed_r & (hcnt_r != H_LAST))
             | (i_px_en & ~hs_fall_s & (hcnt_r == CNT_NEAR));
    v_viol_s = (vs_fall_s & ~v_armed_r & (vcnt_r != V_LAST))
             | (hs_fall_s & ~vs_fall_s & (vcnt_r == CNT_NEAR));
    viol_s   = h_viol_s | v_viol_s;

    visible_s = ({1'b0, hcnt_next_s} >= H_ACT_LO) && ({1'b0, hcnt_next_s} < H_ACT_HI)
             && ({1'b0, vcnt_next_s} >= V_ACT_LO) && ({1'b0, vcnt_next_s} < V_ACT_HI);

    // A violation on a visible strobe suppresses the pixel.
    de_s     = i_px_en & (state_r == ST_LOCK) & ~viol_s & visible_s;
    hcol_s   = hcnt_next_s - H_OFF;
    vrow_s   = vcnt_next_s - V_OFF;
    origin_s = (hcol_s == 10'd0) && (vrow_s[8:0] == 9'd0);
  end

  // Lock FSM next-state and good-frame counting.
  always_comb begin
    state_next_s = state_r;
    good_next_s  = good_r;
    good_inc_s   = good_r + GOOD_ONE;
    case (state_r)
      ST_UNLOCK: begin
        if (vs_fall_s) begin
          state_next_s = ST_TRAIN;
          good_next_s  = GOOD_ZERO;
        end else begin
          state_next_s = ST_UNLOCK;
        end
      end
      ST_TRAIN: begin
        if (viol_s) begin
          good_next_s = GOOD_ZERO;
        end else if (vs_fall_s) begin
          good_next_s = good_inc_s;
          if (good_inc_s == GOOD_TARGET) begin
            state_next_s = ST_LOCK;
          end else begin
            state_next_s = ST_TRAIN;
          end
        end else begin
          good_next_s = good_r;
        end
      end
      ST_LOCK: begin
        if (viol_s) begin
          state_next_s = ST_UNLOCK;
        end else begin
          state_next_s = ST_LOCK;
        end
      end
      default: begin
        state_next_s = ST_UNLOCK;
        good_next_s  = GOOD_ZERO;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      state_r <= ST_UNLOCK;
    end else if (i_px_en) begin
      state_r <= state_next_s;
    end
  end

  // Position counters, sync history and first-edge flags.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      hs_prev_r <= 1'b1;
      vs_prev_r <= 1'b1;
      h_armed_r <= 1'b1;
      v_armed_r <= 1'b1;
      hcnt_r    <= 10'd0;
      vcnt_r    <= 10'd0;
      good_r    <= GOOD_ZERO;
    end else if (i_px_en) begin
      hs_prev_r <= i_vga_hsync;
      if (hs_fall_s) begin
        vs_prev_r <= i_vga_vsync;
        h_armed_r <= 1'b0;
      end
      if (vs_fall_s) begin
        v_armed_r <= 1'b0;
      end
      hcnt_r <= hcnt_next_s;
      vcnt_r <= vcnt_next_s;
      good_r <= good_next_s;
    end
  end

  // Registered outputs; pulses clear on every non-strobe clk.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      o_hidx        <= 10'd0;
      o_vidx        <= 9'd0;
      o_red         <= 4'd0;
      o_green       <= 4'd0;
      o_blue        <= 4'd0;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
      if (i_px_en) begin
        o_err    <= viol_s & (state_r != ST_UNLOCK);
        o_locked <= (state_next_s == ST_LOCK);
        if (de_s) begin
          o_de          <= 1'b1;
          o_frame_start <= origin_s;
          o_hidx        <= hcol_s;
          o_vidx        <= vrow_s[8:0];
          o_red         <= i_vga_red;
          o_green       <= i_vga_green;
          o_blue        <= i_vga_blue;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Self-checking bench for vga_timing_rx on a reduced raster (40x20 strobes) so that
// locking, relocking and saturation all fit in a short run.
module tb_vga_timing_rx;

  localparam int H_TOTAL     = 40;
  localparam int H_ACT_START = 8;
  localparam int V_TOTAL     = 20;
  localparam int V_ACT_START = 14;
  localparam int LOCK_FRAMES = 2;
  localparam int HS_W        = 4;
  localparam int VIS         = (H_TOTAL - H_ACT_START) * (V_TOTAL - V_ACT_START);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_sclr_n, i_px_en, i_vga_hsync, i_vga_vsync;
  logic [3:0] i_vga_red, i_vga_green, i_vga_blue;
  logic [9:0] o_hidx;
  logic [8:0] o_vidx;
  logic [3:0] o_red, o_green, o_blue;
  logic       o_de, o_frame_start, o_locked, o_err;

  vga_timing_rx #(
    .H_TOTAL(H_TOTAL), .H_ACT_START(H_ACT_START), .V_TOTAL(V_TOTAL),
    .V_ACT_START(V_ACT_START), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .i_sclr_n(i_sclr_n), .i_px_en(i_px_en),
    .i_vga_hsync(i_vga_hsync), .i_vga_vsync(i_vga_vsync),
    .i_vga_red(i_vga_red), .i_vga_green(i_vga_green), .i_vga_blue(i_vga_blue),
    .o_hidx(o_hidx), .o_vidx(o_vidx), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_de(o_de), .o_frame_start(o_frame_start), .o_locked(o_locked), .o_err(o_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: integer raster position and lock mode (0 unlocked, 1 training, 2 locked).
  int  m_h, m_v, m_mode, m_good;
  bit  m_hs_prev, m_vs_prev, m_h_seen, m_v_seen;
  logic       e_de, e_fs, e_err, e_locked;
  logic [9:0] e_hidx;
  logic [8:0] e_vidx;
  logic [3:0] e_r, e_g, e_b;

  int de_cnt, fs_cnt, err_cnt, gap_fixed;
  bit ramp_on, fall_pending, first_de_pending;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_mode = 0; m_good = 0;
    m_hs_prev = 1'b1; m_vs_prev = 1'b1; m_h_seen = 1'b0; m_v_seen = 1'b0;
    e_de = 1'b0; e_fs = 1'b0; e_err = 1'b0; e_locked = 1'b0;
    e_hidx = 10'd0; e_vidx = 9'd0; e_r = 4'd0; e_g = 4'd0; e_b = 4'd0;
  endtask

  task automatic model_strobe(input bit hs, input bit vs, input logic [3:0] r,
                              input logic [3:0] g, input logic [3:0] b);
    bit hf, vf, bad, vis;
    int was_mode;
    hf  = (hs == 1'b0) && m_hs_prev;
    vf  = hf && (vs == 1'b0) && m_vs_prev;
    bad = 1'b0;
    if (hf) begin
      if (m_h_seen && m_h != H_TOTAL - 1) bad = 1'b1;
      m_h_seen  = 1'b1;
      m_h       = 0;
      m_vs_prev = vs;
      if (vf) begin
        if (m_v_seen && m_v != V_TOTAL - 1) bad = 1'b1;
        m_v_seen = 1'b1;
        m_v      = 0;
      end else if (m_v < 1023) begin
        m_v++;
        if (m_v == 1023) bad = 1'b1;
      end
    end else if (m_h < 1023) begin
      m_h++;
      if (m_h == 1023) bad = 1'b1;
    end
    m_hs_prev = hs;
    vis = (m_h >= H_ACT_START) && (m_h < H_ACT_START + 640) &&
          (m_v >= V_ACT_START) && (m_v < V_ACT_START + 480);
    was_mode = m_mode;
    case (m_mode)
      0: if (vf) begin m_mode = 1; m_good = 0; end
      1: if (bad) m_good = 0;
         else if (vf) begin
           m_good++;
           if (m_good == LOCK_FRAMES) m_mode = 2;
         end
      2: if (bad) m_mode = 0;
      default: m_mode = 0;
    endcase
    e_err    = bad && (was_mode != 0);
    e_locked = (m_mode == 2);
    e_de     = (was_mode == 2) && !bad && vis;
    e_fs     = 1'b0;
    if (e_de) begin
      e_hidx = 10'(m_h - H_ACT_START);
      e_vidx = 9'(m_v - V_ACT_START);
      e_r = r; e_g = g; e_b = b;
      e_fs = (e_hidx == 10'd0) && (e_vidx == 9'd0);
    end
  endtask

  task automatic cyc(input bit px, input bit hs, input bit vs, input logic [3:0] r,
                     input logic [3:0] g, input logic [3:0] b, input bit clr);
    i_px_en = px; i_vga_hsync = hs; i_vga_vsync = vs;
    i_vga_red = r; i_vga_green = g; i_vga_blue = b; i_sclr_n = !clr;
    if (clr) model_reset();
    else if (px) model_strobe(hs, vs, r, g, b);
    else begin e_de = 1'b0; e_fs = 1'b0; e_err = 1'b0; end
    @(posedge clk);
    #1;
    if (fall_pending) begin
      chk("de_fall_after_strobe", o_de, 1'b0);
      fall_pending = 1'b0;
    end
    chk("de", o_de, e_de);
    chk("frame_start", o_frame_start, e_fs);
    chk("err", o_err, e_err);
    chk("locked", o_locked, e_locked);
    chk("hidx", o_hidx, e_hidx);
    chk("vidx", o_vidx, e_vidx);
    chk("rgb", {o_red, o_green, o_blue}, {e_r, e_g, e_b});
    if (o_de && first_de_pending) begin
      chk("first_de_has_frame_start", o_frame_start, 1'b1);
      first_de_pending = 1'b0;
    end
    if (ramp_on && o_de && o_hidx == 10'd5) begin
      chk("ramp_red_at_col5", o_red, 4'd5);
      fall_pending = 1'b1;
    end
    if (o_de) de_cnt++;
    if (o_frame_start) fs_cnt++;
    if (o_err) err_cnt++;
  endtask

  task automatic strobe(input bit hs, input bit vs, input logic [3:0] r,
                        input logic [3:0] g, input logic [3:0] b);
    int gap;
    gap = (gap_fixed > 0) ? gap_fixed : int'($urandom_range(1, 3));
    for (int k = 1; k < gap; k++)
      cyc(1'b0, i_vga_hsync, i_vga_vsync, i_vga_red, i_vga_green, i_vga_blue, 1'b0);
    cyc(1'b1, hs, vs, r, g, b, 1'b0);
  endtask

  task automatic line(input int len, input bit vs_low, input int rst_at);
    logic [3:0] r;
    bit hs;
    for (int x = 0; x < len; x++) begin
      r  = ramp_on ? 4'(x - H_ACT_START) : 4'($urandom);
      hs = (x < HS_W) ? 1'b0 : 1'b1;
      if (x == rst_at) begin
        cyc(1'b1, hs, !vs_low, r, 4'($urandom), 4'($urandom), 1'b1);
        chk("sclr_clears_outputs",
            {o_de, o_frame_start, o_locked, o_err, o_hidx, o_vidx, o_red, o_green, o_blue},
            40'd0);
      end
      strobe(hs, !vs_low, r, 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic frame(input int nlines, input int long_y, input int rst_y);
    for (int y = 0; y < nlines; y++)
      line((y == long_y) ? H_TOTAL + 1 : H_TOTAL, y < 2,
           (y == rst_y) ? H_ACT_START + 5 : -1);
  endtask

  initial begin
    i_sclr_n = 1'b1; i_px_en = 1'b0; i_vga_hsync = 1'b1; i_vga_vsync = 1'b1;
    i_vga_red = 4'd0; i_vga_green = 4'd0; i_vga_blue = 4'd0;
    de_cnt = 0; fs_cnt = 0; err_cnt = 0;
    fall_pending = 1'b0; first_de_pending = 1'b0;
    model_reset();

    // Reset with strobes present, then nominal stream on every 4th clk with a colour ramp.
    cyc(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 4'h3, 1'b1);
    chk("reset_locked", o_locked, 1'b0);
    chk("reset_de", o_de, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0);
    gap_fixed = 4; ramp_on = 1'b1;
    frame(V_TOTAL, -1, -1);
    frame(V_TOTAL, -1, -1);
    chk("unlocked_before_3rd_vfall", o_locked, 1'b0);
    de_cnt = 0; fs_cnt = 0; first_de_pending = 1'b1;
    frame(V_TOTAL, -1, -1);
    chk("locked_after_3rd_vfall", o_locked, 1'b1);
    chk("de_per_frame", de_cnt, VIS);
    chk("fs_per_frame", fs_cnt, 1);

    // One overlong line while locked, then relock after two clean frames.
    ramp_on = 1'b0; gap_fixed = 0; err_cnt = 0;
    frame(V_TOTAL, 5, -1);
    chk("long_line_err_count", err_cnt, 1);
    chk("long_line_unlocks", o_locked, 1'b0);
    de_cnt = 0;
    frame(V_TOTAL, -1, -1);
    frame(V_TOTAL, -1, -1);
    chk("no_de_during_relock", de_cnt, 0);
    chk("still_unlocked", o_locked, 1'b0);
    de_cnt = 0;
    frame(V_TOTAL, -1, -1);
    chk("relocked", o_locked, 1'b1);
    chk("relock_de_per_frame", de_cnt, VIS);

    // Short frame: vsync fall arrives two lines early.
    err_cnt = 0;
    frame(V_TOTAL - 2, -1, -1);
    chk("short_frame_not_yet_seen", o_locked, 1'b1);
    frame(V_TOTAL, -1, -1);
    chk("short_frame_err_count", err_cnt, 1);
    chk("short_frame_unlocks", o_locked, 1'b0);
    frame(V_TOTAL, -1, -1);
    frame(V_TOTAL, -1, -1);
    frame(V_TOTAL, -1, -1);
    chk("relocked_after_short", o_locked, 1'b1);

    // hsync stuck high long enough for the line counter to saturate.
    err_cnt = 0;
    line(1100, 1'b0, -1);
    chk("hsat_err_count", err_cnt, 1);
    chk("hsat_unlocks", o_locked, 1'b0);
    frame(V_TOTAL, -1, -1);
    frame(V_TOTAL, -1, -1);
    frame(V_TOTAL, -1, -1);
    chk("relocked_after_hsat", o_locked, 1'b1);

    // Clear pulse in the middle of a visible line.
    frame(V_TOTAL, -1, V_ACT_START + 1);
    de_cnt = 0;
    frame(V_TOTAL, -1, -1);
    frame(V_TOTAL, -1, -1);
    chk("no_de_after_sclr", de_cnt, 0);
    chk("unlocked_after_sclr", o_locked, 1'b0);
    de_cnt = 0;
    frame(V_TOTAL, -1, -1);
    chk("relocked_after_sclr", o_locked, 1'b1);
    chk("sclr_relock_de_per_frame", de_cnt, VIS);

    // Random tail: frames with an occasional overlong line somewhere.
    frame(V_TOTAL, int'($urandom_range(0, 3 * V_TOTAL)), -1);
    frame(V_TOTAL, int'($urandom_range(0, 3 * V_TOTAL)), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning pixel strobes per line.
REQ-002 SHALL have parameter H_ACT_START, default 144, meaning hcnt of the first visible pixel (96 sync + 48 back porch).
REQ-003 SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-004 SHALL have parameter V_ACT_START, default 34, meaning vcnt of the first visible line in hsync-fall framing.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive good frames required for lock.
REQ-006 clk  in  1  system clock; the only clock.
REQ-007 i_sclr_n  in  1  synchronous, active-low clear.
REQ-008 i_px_en  in  1  pixel strobe, one clk wide; all sampling is qualified by it.
REQ-009 i_vga_hsync, i_vga_vsync  in  1 each  sync inputs, active low.
REQ-010 i_vga_red, i_vga_green, i_vga_blue  in  4 each  colour inputs.
REQ-011 o_hidx  out  10  visible column, 0..639.
REQ-012 o_vidx  out  9  visible row, 0..479.
REQ-013 o_red, o_green, o_blue  out  4 each  captured colour.
REQ-014 o_de  out  1  one-clk pulse per captured visible pixel.
REQ-015 o_frame_start  out  1  one-clk pulse coincident with o_de at pixel (0,0).
REQ-016 o_locked  out  1  level, timing locked.
REQ-017 o_err  out  1  one-clk pulse on a timing violation while locked or training.

Function
REQ-018 All state SHALL advance only on clk cycles with i_px_en=1, except output pulses, which SHALL deassert on the following clk.
REQ-019 An hsync fall SHALL be a strobe where the sampled hsync is 0 and the previous strobe's sample is 1; the vsync fall is defined the same way but sampled only at hsync-fall strobes.
REQ-020 hcnt (10 bit) SHALL load 0 on an hsync fall; otherwise it SHALL increment and saturate at 1023.
REQ-021 vcnt (10 bit) SHALL load 0 on an hsync fall with a vsync fall; on any other hsync fall it SHALL increment and saturate at 1023.
REQ-022 An h-violation SHALL occur when an hsync fall arrives with hcnt != H_TOTAL-1, or when hcnt reaches 1023.
REQ-023 A v-violation SHALL occur when a vsync fall arrives with vcnt != V_TOTAL-1, or when vcnt reaches 1023.
REQ-024 The first hsync fall and the first vsync fall after reset SHALL NOT be checked.
REQ-025 The lock FSM SHALL have three states:
- UNLOCK: go to TRAIN on a vsync fall, with good-frame count cleared.
- TRAIN: a violation clears the count and stays in TRAIN; a clean vsync fall increments the count; count == LOCK_FRAMES goes to LOCK.
- LOCK: any violation goes to UNLOCK.
REQ-026 o_err SHALL pulse for every violation detected in TRAIN or LOCK.
REQ-027 o_locked SHALL be 1 only in LOCK, asserting on the clk after the transition.
REQ-028 A pixel SHALL be visible when H_ACT_START <= hcnt < H_ACT_START+640 and V_ACT_START <= vcnt < V_ACT_START+480, with hcnt/vcnt taken after the update on that strobe.
REQ-029 On a visible strobe in LOCK, one clk later:
- o_de SHALL be 1;
- o_hidx SHALL be hcnt-H_ACT_START and o_vidx SHALL be vcnt-V_ACT_START, truncated to width;
- colours SHALL be those sampled on the strobe.
REQ-030 o_hidx, o_vidx and the colour outputs SHALL hold their values between o_de pulses.
REQ-031 o_frame_start SHALL pulse with the o_de pulse where o_hidx=0 and o_vidx=0.
REQ-032 If a violation and a visible pixel occur on the same strobe, the violation SHALL win: no o_de, o_err=1, o_locked drops.

Reset
REQ-033 On clk with i_sclr_n=0, regardless of i_px_en:
- hcnt=0, vcnt=0 and good-frame count=0;
- previous-sample registers=1 (idle high);
- FSM=UNLOCK and first-edge flags armed;
- all outputs=0.
REQ-034 Reset asserted mid-frame SHALL take effect on that clk; the first o_de after release SHALL follow a full relock.

Verification
REQ-035 Reset, then nominal 640x480 stream with i_px_en every 4th clk -> o_locked rises after the 3rd vsync fall, then exactly 307200 o_de per frame, first one with o_frame_start=1.
REQ-036 Ramp colour red=hidx[3:0] -> at o_de with o_hidx=5, o_red=5, and o_de falls exactly 1 clk after the strobe.
REQ-037 While locked, one line of 801 strobes -> single o_err pulse, o_locked=0 on the next clk, no o_de until relock after 2 clean frames.
REQ-038 Locked, vsync fall moved to line 523 -> o_err pulse, o_locked=0.
REQ-039 hsync held high -> hcnt saturates at 1023, o_err pulses once, o_locked=0.
REQ-040 i_sclr_n=0 for 1 clk mid-visible-line -> all outputs 0 on the next clk; relock after 3 vsync falls.
